// File: rtl/fir_out_stage.sv
// fir_out_stage: scales, rounds and (optionally) saturates FIR results, then buffers them behind a ready/valid port.
// Optional macro FIR_OUT_SAT_EN enables saturation; without it results wrap to OUT_SIZE bits.
module fir_out_stage #(
    parameter int Y_N_SIZE = 14,
    parameter int OUT_SIZE = 8,
    parameter int SHIFT_W  = 3,
    parameter int DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [Y_N_SIZE-1:0]    y_n,
    input  logic                   y_valid,
    input  logic [SHIFT_W-1:0]     shift_sel,
    input  logic                   m_tready,
    output logic [OUT_SIZE-1:0]    m_tdata,
    output logic                   m_tvalid,
    output logic                   sat_flag,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EXT_W = Y_N_SIZE + 1;
`ifdef FIR_OUT_SAT_EN
    localparam int ENTRY_W = OUT_SIZE + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((2 ** (OUT_SIZE - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`else
    localparam int ENTRY_W = OUT_SIZE;
`endif

    logic [Y_N_SIZE-1:0] s1_data_reg;
    logic [SHIFT_W-1:0]  s1_shift_reg;
    logic                s1_valid_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_data_reg  <= '0;
            s1_shift_reg <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= y_valid;
            if (y_valid) begin
                s1_data_reg  <= y_n;
                s1_shift_reg <= shift_sel;
            end
        end
    end

    logic signed [EXT_W-1:0] ext_val;
    logic signed [EXT_W-1:0] round_add;
    logic signed [EXT_W-1:0] rounded;
    logic [OUT_SIZE-1:0]     s2_data_next;
`ifdef FIR_OUT_SAT_EN
    logic signed [EXT_W-1:0] shifted;
    logic                    s2_sat_next;
`else
    // Sign-padded so a variable part-select acts as an arithmetic shift for any shift amount.
    logic [EXT_W+(2**SHIFT_W)-1:0] rounded_pad;
`endif

    always_comb begin
        ext_val   = {s1_data_reg[Y_N_SIZE-1], s1_data_reg};
        round_add = '0;
        if (s1_shift_reg != '0)
            round_add = EXT_W'(1) << (s1_shift_reg - SHIFT_W'(1));
        rounded = ext_val + round_add;
`ifdef FIR_OUT_SAT_EN
        shifted = rounded >>> s1_shift_reg;
        if (shifted > SAT_MAX) begin
            s2_data_next = SAT_MAX[OUT_SIZE-1:0];
            s2_sat_next  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            s2_data_next = SAT_MIN[OUT_SIZE-1:0];
            s2_sat_next  = 1'b1;
        end else begin
            s2_data_next = shifted[OUT_SIZE-1:0];
            s2_sat_next  = 1'b0;
        end
`else
        rounded_pad  = {{(2**SHIFT_W){rounded[EXT_W-1]}}, rounded};
        s2_data_next = rounded_pad[s1_shift_reg +: OUT_SIZE];
`endif
    end

    logic [OUT_SIZE-1:0] s2_data_reg;
    logic                s2_valid_reg;
`ifdef FIR_OUT_SAT_EN
    logic                s2_sat_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_data_reg  <= '0;
            s2_valid_reg <= 1'b0;
`ifdef FIR_OUT_SAT_EN
            s2_sat_reg   <= 1'b0;
`endif
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_data_reg  <= s2_data_next;
`ifdef FIR_OUT_SAT_EN
            s2_sat_reg   <= s2_sat_next;
`endif
        end
    end

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               overflow_reg;
    logic               push;
    logic               pop;
    logic               accept;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

`ifdef FIR_OUT_SAT_EN
    assign wr_entry = {s2_sat_reg, s2_data_reg};
`else
    assign wr_entry = s2_data_reg;
`endif

    assign push   = s2_valid_reg;
    assign pop    = (count_reg != '0) && m_tready;
    // A full FIFO still takes a sample when the head leaves on the same edge.
    assign accept = push && ((count_reg < CNT_W'(DEPTH)) || pop);

    always_comb begin
        count_next = count_reg;
        case ({accept, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr_reg] <= wr_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (accept)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            if (push && !accept)
                overflow_reg <= 1'b1;
        end
    end

    assign head_entry = mem[rd_ptr_reg];
    assign m_tvalid   = (count_reg != '0);
    // Gating with m_tvalid keeps stale storage off the pins while empty or in reset.
    assign m_tdata    = m_tvalid ? head_entry[OUT_SIZE-1:0] : '0;
`ifdef FIR_OUT_SAT_EN
    assign sat_flag   = m_tvalid & head_entry[OUT_SIZE];
`else
    assign sat_flag   = 1'b0;
`endif
    assign overflow   = overflow_reg;
    assign level      = count_reg;

endmodule

// File: tb/tb_fir_out_stage.sv
// tb_fir_out_stage: directed scenarios for fir_out_stage plus a randomized run checked against a queue model.
module tb_fir_out_stage;
    localparam int Y_N_SIZE = 14;
    localparam int OUT_SIZE = 8;
    localparam int SHIFT_W  = 3;
    localparam int DEPTH    = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [Y_N_SIZE-1:0]    y_n;
    logic                   y_valid;
    logic [SHIFT_W-1:0]     shift_sel;
    logic                   m_tready;
    logic [OUT_SIZE-1:0]    m_tdata;
    logic                   m_tvalid;
    logic                   sat_flag;
    logic                   overflow;
    logic [$clog2(DEPTH):0] level;

    int total = 0;
    int bad   = 0;

    fir_out_stage #(
        .Y_N_SIZE(Y_N_SIZE),
        .OUT_SIZE(OUT_SIZE),
        .SHIFT_W (SHIFT_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .y_n      (y_n),
        .y_valid  (y_valid),
        .shift_sel(shift_sel),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .sat_flag (sat_flag),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        y_valid = 1'b0;
        m_tready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One y_valid pulse, then wait until the sample has reached the FIFO head.
    task automatic send_sample(input int y, input int s);
        y_n       = Y_N_SIZE'(y);
        shift_sel = SHIFT_W'(s);
        y_valid   = 1'b1;
        tick();
        y_valid = 1'b0;
        tick();
        tick();
    endtask

    // Reference: round half up, floor-divide by 2^s, then clamp or wrap.
    function automatic void ref_scale(input int y, input int s, output int val, output bit sat);
        int v, d, q, hi, lo;
        hi = (1 << (OUT_SIZE - 1)) - 1;
        lo = -(1 << (OUT_SIZE - 1));
        v = y + ((s > 0) ? (1 << (s - 1)) : 0);
        d = 1 << s;
        q = v / d;
        if ((v % d != 0) && (v < 0))
            q = q - 1;
        sat = 1'b0;
`ifdef FIR_OUT_SAT_EN
        if (q > hi) begin
            q = hi;
            sat = 1'b1;
        end else if (q < lo) begin
            q = lo;
            sat = 1'b1;
        end
        val = q;
`else
        val = q & ((1 << OUT_SIZE) - 1);
        if (val > hi)
            val = val - (1 << OUT_SIZE);
`endif
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        y_valid   = 1'b0;
        y_n       = '0;
        shift_sel = '0;
        m_tready  = 1'b0;
        tick();
        tick();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        total++; if (m_tdata !== '0) begin bad++; $display("FAIL reset_tdata: got %0h want 0", m_tdata); end
        total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        reset = 1'b0;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        m_tready  = 1'b1;
        shift_sel = '0;
        y_n       = Y_N_SIZE'(100);
        y_valid   = 1'b1;
        tick();
        y_valid = 1'b0;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL basic_early1: tvalid got %b want 0", m_tvalid); end
        tick();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL basic_early2: tvalid got %b want 0", m_tvalid); end
        tick();
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL basic_valid: tvalid got %b want 1", m_tvalid); end
        total++; if (m_tdata !== 8'd100) begin bad++; $display("FAIL basic_data: got %0d want 100", $signed(m_tdata)); end
        total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL basic_sat: got %b want 0", sat_flag); end
        tick();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL basic_oneshot: tvalid got %b want 0", m_tvalid); end
        $display("test_basic: y_n=100 shift=0 -> one output");
    endtask

    task automatic test_saturation();
        int ys[2];
        logic [OUT_SIZE-1:0] exp_d[2];
        logic exp_s[2];
        ys = '{200, -300};
`ifdef FIR_OUT_SAT_EN
        exp_d = '{8'd127, 8'h80};
        exp_s = '{1'b1, 1'b1};
`else
        exp_d = '{8'hC8, 8'hD4};
        exp_s = '{1'b0, 1'b0};
`endif
        m_tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_sample(ys[i], 0);
            total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL sat_valid[%0d]: got %b want 1", i, m_tvalid); end
            total++; if (m_tdata !== exp_d[i]) begin bad++; $display("FAIL sat_data[%0d]: got %0h want %0h", i, m_tdata, exp_d[i]); end
            total++; if (sat_flag !== exp_s[i]) begin bad++; $display("FAIL sat_flag[%0d]: got %b want %b", i, sat_flag, exp_s[i]); end
            $display("test_saturation: y_n=%0d -> %0h sat=%b", ys[i], m_tdata, sat_flag);
            tick();
        end
    endtask

    task automatic test_rounding();
        int ys[4];
        int ss[4];
        int exps[4];
        ys   = '{5, 6, -6, 8191};
        ss   = '{2, 2, 2, 7};
        exps = '{1, 2, -1, 64};
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_sample(ys[i], ss[i]);
            total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL round_valid[%0d]: got %b want 1", i, m_tvalid); end
            total++; if (m_tdata !== OUT_SIZE'(exps[i])) begin bad++; $display("FAIL round_data[%0d]: got %0d want %0d", i, $signed(m_tdata), exps[i]); end
            total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL round_sat[%0d]: got %b want 0", i, sat_flag); end
            $display("test_rounding: y_n=%0d shift=%0d -> %0d", ys[i], ss[i], $signed(m_tdata));
            tick();
        end
    endtask

    task automatic test_full();
        m_tready  = 1'b0;
        shift_sel = '0;
        for (int i = 1; i <= 5; i++) begin
            y_n     = Y_N_SIZE'(i);
            y_valid = 1'b1;
            tick();
        end
        y_valid = 1'b0;
        tick();
        tick();
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level: got %0d want 4", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow: got %b want 1", overflow); end
        m_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (m_tvalid !== 1'b1 || m_tdata !== OUT_SIZE'(i)) begin
                bad++; $display("FAIL full_drain[%0d]: got valid=%b data=%0d want valid=1 data=%0d", i, m_tvalid, m_tdata, i);
            end
            tick();
        end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL full_dropped: tvalid got %b want 0 (data %0d)", m_tvalid, m_tdata); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_sticky: got %b want 1", overflow); end
        $display("test_full: drained 1..4, sample 5 dropped");
    endtask

    task automatic test_async_reset();
        m_tready  = 1'b0;
        shift_sel = '0;
        for (int i = 10; i <= 13; i++) begin
            y_n     = Y_N_SIZE'(i);
            y_valid = 1'b1;
            tick();
        end
        y_valid = 1'b0;
        tick();
        total++; if (level !== 3'd3) begin bad++; $display("FAIL areset_pre_level: got %0d want 3", level); end
        #3;
        reset = 1'b1;
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL areset_tvalid: got %b want 0", m_tvalid); end
        total++; if (level !== '0) begin bad++; $display("FAIL areset_level: got %0d want 0", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL areset_overflow: got %b want 0", overflow); end
        total++; if (m_tdata !== '0) begin bad++; $display("FAIL areset_tdata: got %0h want 0", m_tdata); end
        tick();
        reset    = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL areset_ghost[%0d]: tvalid got %b want 0", i, m_tvalid); end
        end
        send_sample(42, 0);
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 8'd42) begin
            bad++; $display("FAIL areset_fresh: got valid=%b data=%0d want valid=1 data=42", m_tvalid, m_tdata);
        end
        tick();
        $display("test_async_reset: contents discarded, fresh sample 42 delivered");
    endtask

    task automatic test_push_pop_full();
        int exp_order[4];
        exp_order = '{2, 3, 4, 9};
        do_reset();
        shift_sel = '0;
        for (int i = 1; i <= 4; i++) begin
            y_n     = Y_N_SIZE'(i);
            y_valid = 1'b1;
            tick();
        end
        y_valid = 1'b0;
        tick();
        tick();
        total++; if (level !== 3'd4) begin bad++; $display("FAIL pp_level_pre: got %0d want 4", level); end
        y_n     = Y_N_SIZE'(9);
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        tick();
        m_tready = 1'b1;
        total++; if (m_tdata !== 8'd1) begin bad++; $display("FAIL pp_head_pre: got %0d want 1", m_tdata); end
        tick();
        total++; if (level !== 3'd4) begin bad++; $display("FAIL pp_level: got %0d want 4", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow: got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            total++; if (m_tvalid !== 1'b1 || m_tdata !== OUT_SIZE'(exp_order[i])) begin
                bad++; $display("FAIL pp_drain[%0d]: got valid=%b data=%0d want valid=1 data=%0d", i, m_tvalid, m_tdata, exp_order[i]);
            end
            tick();
        end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL pp_empty: tvalid got %b want 0", m_tvalid); end
        $display("test_push_pop_full: drain order 2,3,4,9");
    endtask

    task automatic test_random();
        int qv[$];
        bit qs[$];
        int pend_due[$];
        int pend_val[$];
        bit pend_sat[$];
        bit m_ovf;
        int y, s, thr, v;
        bit yv, rdy, sat;
        do_reset();
        m_ovf = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            thr = (cyc / 100) % 3;
            rdy = ($urandom % 4) < ((thr == 0) ? 1 : (thr == 1) ? 3 : 4);
            yv  = ($urandom % 4) != 0;
            case ($urandom % 8)
                0:       y = 8191;
                1:       y = -8192;
                default: y = int'($urandom_range(16383)) - 8192;
            endcase
            s = int'($urandom_range(7));
            y_n       = Y_N_SIZE'(y);
            shift_sel = SHIFT_W'(s);
            y_valid   = yv;
            m_tready  = rdy;
            tick();
            // Model of the edge just taken: head leaves, then a sample due now tries to enter.
            if (qv.size() > 0 && rdy) begin
                void'(qv.pop_front());
                void'(qs.pop_front());
            end
            if (pend_due.size() > 0 && pend_due[0] == cyc) begin
                if (qv.size() < DEPTH) begin
                    qv.push_back(pend_val[0]);
                    qs.push_back(pend_sat[0]);
                end else begin
                    m_ovf = 1'b1;
                end
                void'(pend_due.pop_front());
                void'(pend_val.pop_front());
                void'(pend_sat.pop_front());
            end
            if (yv) begin
                ref_scale(y, s, v, sat);
                pend_due.push_back(cyc + 2);
                pend_val.push_back(v);
                pend_sat.push_back(sat);
            end
            total++; if (m_tvalid !== (qv.size() != 0)) begin bad++; $display("FAIL rnd_tvalid@%0d: got %b want %b", cyc, m_tvalid, qv.size() != 0); end
            total++; if (level !== 3'(qv.size())) begin bad++; $display("FAIL rnd_level@%0d: got %0d want %0d", cyc, level, qv.size()); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow@%0d: got %b want %b", cyc, overflow, m_ovf); end
            if (qv.size() != 0) begin
                total++; if (m_tdata !== OUT_SIZE'(qv[0])) begin bad++; $display("FAIL rnd_data@%0d: got %0d want %0d", cyc, $signed(m_tdata), qv[0]); end
                total++; if (sat_flag !== qs[0]) begin bad++; $display("FAIL rnd_sat@%0d: got %b want %b", cyc, sat_flag, qs[0]); end
            end
        end
        $display("test_random: 600 cycles checked");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_rounding();
        test_full();
        test_async_reset();
        test_push_pop_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
